// File: rtl/param_reg_file.sv
// Parameterised register file with a reserve/clear scoreboard.
// Register 0 reads as zero and is never busy. Optional write-to-read forwarding.
module param_reg_file #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rr1,
  input  logic [ADDR_W-1:0] rr2,
  input  logic [ADDR_W-1:0] wr,
  input  logic [DATA_W-1:0] wd,
  input  logic              regwrite,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic wr_valid;
  logic fwd1;
  logic fwd2;

  // Writes to register 0 are discarded so it stays hard-wired to zero.
  assign wr_valid = regwrite && (wr != '0);

  // Next-state for data: write wd into the addressed register.
  always_comb begin
    regs_d = regs_q;
    if (wr_valid) begin
      regs_d[wr] = wd;
    end
    regs_d[0] = '0;
  end

  // Next-state for scoreboard: write clears, reserve sets; reserve applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (regwrite) begin
      busy_d[wr] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous clear of data and busy bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Forwarding is only meaningful for a real (non-zero) write in this cycle.
  always_comb begin
    fwd1 = (BYPASS != 0) && wr_valid && (wr == rr1);
    fwd2 = (BYPASS != 0) && wr_valid && (wr == rr2);
  end

  // Combinational read ports; a forwarded value is by definition not pending.
  always_comb begin
    rd1   = fwd1 ? wd : regs_q[rr1];
    rd2   = fwd2 ? wd : regs_q[rr2];
    busy1 = fwd1 ? 1'b0 : busy_q[rr1];
    busy2 = fwd2 ? 1'b0 : busy_q[rr2];
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: one forwarding and one non-forwarding instance
// share all inputs so bypass behaviour can be contrasted cycle by cycle.
module tb_param_reg_file;

  logic        clock;
  logic        reset_n;
  logic [1:0]  rr1, rr2, wr, rsv_addr;
  logic [15:0] wd;
  logic        regwrite, rsv_en;

  logic [15:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic        b_busy1, b_busy2, n_busy1, n_busy2;

  int n_checks = 0;
  int n_fail   = 0;

  param_reg_file #(.DATA_W(16), .ADDR_W(2), .BYPASS(1)) u_byp (
    .clock    (clock),
    .reset_n  (reset_n),
    .rr1      (rr1),
    .rr2      (rr2),
    .wr       (wr),
    .wd       (wd),
    .regwrite (regwrite),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd1      (b_rd1),
    .rd2      (b_rd2),
    .busy1    (b_busy1),
    .busy2    (b_busy2)
  );

  param_reg_file #(.DATA_W(16), .ADDR_W(2), .BYPASS(0)) u_nobyp (
    .clock    (clock),
    .reset_n  (reset_n),
    .rr1      (rr1),
    .rr2      (rr2),
    .wr       (wr),
    .wd       (wd),
    .regwrite (regwrite),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd1      (n_rd1),
    .rd2      (n_rd2),
    .busy1    (n_busy1),
    .busy2    (n_busy2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full write cycle: drive at negedge, take the edge, deassert at next negedge.
  task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
    @(negedge clock);
    regwrite = 1'b1;
    wr       = a;
    wd       = d;
    @(posedge clock);
    #1;
    @(negedge clock);
    regwrite = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    rr1      = '0;
    rr2      = '0;
    wr       = '0;
    rsv_addr = '0;
    wd       = '0;
    regwrite = 1'b0;
    rsv_en   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Reset state on every address
    for (int i = 0; i < 4; i++) begin
      rr1 = 2'(i);
      rr2 = 2'(i);
      #1;
      check($sformatf("rst_rd1_%0d", i), b_rd1, 16'h0000);
      check($sformatf("rst_rd2_%0d", i), n_rd2, 16'h0000);
      check($sformatf("rst_busy1_%0d", i), b_busy1, 1'b0);
      check($sformatf("rst_busy2_%0d", i), n_busy2, 1'b0);
    end

    // Basic writes and dual read
    write_reg(2'd1, 16'hA5A5);
    write_reg(2'd2, 16'h1234);
    write_reg(2'd3, 16'hFFFF);
    rr1 = 2'd1;
    rr2 = 2'd3;
    #1;
    check("wr_b_rd1", b_rd1, 16'hA5A5);
    check("wr_b_rd2", b_rd2, 16'hFFFF);
    check("wr_n_rd1", n_rd1, 16'hA5A5);
    check("wr_n_rd2", n_rd2, 16'hFFFF);
    rr2 = 2'd2;
    #1;
    check("wr_n_rd2_r2", n_rd2, 16'h1234);

    // Register 0 ignores writes, including no forwarding of wd
    @(negedge clock);
    regwrite = 1'b1;
    wr       = 2'd0;
    wd       = 16'hBEEF;
    rr1      = 2'd0;
    #1;
    check("r0_fwd_b", b_rd1, 16'h0000);
    @(posedge clock);
    #1;
    @(negedge clock);
    regwrite = 1'b0;
    #1;
    check("r0_b", b_rd1, 16'h0000);
    check("r0_n", n_rd1, 16'h0000);

    // Forwarding vs. no forwarding
    @(negedge clock);
    regwrite = 1'b1;
    wr       = 2'd2;
    wd       = 16'h00C3;
    rr1      = 2'd2;
    #1;
    check("byp_before_b", b_rd1, 16'h00C3);
    check("byp_before_n", n_rd1, 16'h1234);
    @(posedge clock);
    #1;
    check("byp_after_n", n_rd1, 16'h00C3);
    @(negedge clock);
    regwrite = 1'b0;
    #1;
    check("byp_after_b", b_rd1, 16'h00C3);

    // Reserve reg 3
    rsv_en   = 1'b1;
    rsv_addr = 2'd3;
    rr1      = 2'd3;
    #1;
    check("rsv_pre_busy", b_busy1, 1'b0);
    @(posedge clock);
    #1;
    check("rsv_busy_b", b_busy1, 1'b1);
    check("rsv_busy_n", n_busy1, 1'b1);

    // Write reg 3 clears the reservation; forwarding hides busy early
    @(negedge clock);
    rsv_en   = 1'b0;
    regwrite = 1'b1;
    wr       = 2'd3;
    wd       = 16'h0042;
    #1;
    check("clr_fwd_busy_b", b_busy1, 1'b0);
    check("clr_fwd_rd_b", b_rd1, 16'h0042);
    check("clr_pre_busy_n", n_busy1, 1'b1);
    check("clr_pre_rd_n", n_rd1, 16'hFFFF);
    @(posedge clock);
    #1;
    @(negedge clock);
    regwrite = 1'b0;
    #1;
    check("clr_busy_b", b_busy1, 1'b0);
    check("clr_busy_n", n_busy1, 1'b0);
    check("clr_rd_n", n_rd1, 16'h0042);

    // Reserve and write same address: reserve wins, data still stored
    rsv_en   = 1'b1;
    rsv_addr = 2'd3;
    regwrite = 1'b1;
    wr       = 2'd3;
    wd       = 16'h0042;
    @(posedge clock);
    #1;
    @(negedge clock);
    rsv_en   = 1'b0;
    regwrite = 1'b0;
    #1;
    check("same_busy", n_busy1, 1'b1);
    check("same_rd", n_rd1, 16'h0042);

    // Reserve reg 1 while writing reg 3: both effects land
    rsv_en   = 1'b1;
    rsv_addr = 2'd1;
    regwrite = 1'b1;
    wr       = 2'd3;
    wd       = 16'h0777;
    @(posedge clock);
    #1;
    @(negedge clock);
    rsv_en   = 1'b0;
    regwrite = 1'b0;
    rr1      = 2'd1;
    rr2      = 2'd3;
    #1;
    check("diff_busy1", b_busy1, 1'b1);
    check("diff_busy3", b_busy2, 1'b0);
    check("diff_rd3", b_rd2, 16'h0777);

    // Reserving reg 0 is a no-op
    rsv_en   = 1'b1;
    rsv_addr = 2'd0;
    @(posedge clock);
    #1;
    @(negedge clock);
    rsv_en = 1'b0;
    rr1    = 2'd0;
    #1;
    check("r0_busy", b_busy1, 1'b0);

    // regwrite=0 over three edges leaves reg 1 alone
    wr = 2'd1;
    wd = 16'h5555;
    repeat (3) @(posedge clock);
    @(negedge clock);
    rr1 = 2'd1;
    #1;
    check("nowr_rd1", b_rd1, 16'hA5A5);
    check("nowr_busy1", b_busy1, 1'b1);

    // Reserve reg 2, then async reset mid-cycle
    rsv_en   = 1'b1;
    rsv_addr = 2'd2;
    @(posedge clock);
    #1;
    @(negedge clock);
    rsv_en = 1'b0;
    rr2    = 2'd2;
    #1;
    check("pre_rst_busy2", b_busy2, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy2", b_busy2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rr1 = 2'(i);
      #1;
      check($sformatf("arst_rd_%0d", i), b_rd1, 16'h0000);
      check($sformatf("arst_busy_%0d", i), n_busy1, 1'b0);
    end

    // Writes and reserves ignored during reset; forwarding still visible
    @(negedge clock);
    regwrite = 1'b1;
    wr       = 2'd1;
    wd       = 16'h7777;
    rsv_en   = 1'b1;
    rsv_addr = 2'd1;
    rr1      = 2'd1;
    #1;
    check("inrst_fwd_b", b_rd1, 16'h7777);
    check("inrst_nofwd_n", n_rd1, 16'h0000);
    @(posedge clock);
    #1;
    @(negedge clock);
    regwrite = 1'b0;
    rsv_en   = 1'b0;
    #1;
    check("inrst_rd_b", b_rd1, 16'h0000);
    check("inrst_busy_b", b_busy1, 1'b0);
    reset_n = 1'b1;

    // First edge after reset writes reg 2 normally
    regwrite = 1'b1;
    wr       = 2'd2;
    wd       = 16'h9999;
    rr2      = 2'd2;
    @(posedge clock);
    #1;
    @(negedge clock);
    regwrite = 1'b0;
    #1;
    check("post_rst_rd2", n_rd2, 16'h9999);
    check("post_rst_busy2", n_busy2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001: Parameter DATA_W, default 16, SHALL set the data width of every register, wd, rd1 and rd2.
REQ-002: Parameter ADDR_W, default 2, SHALL set the register address width; register count NREGS = 2**ADDR_W.
REQ-003: Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1 and disable it when 0.
REQ-004: clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005: reset_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006: rr1  input  ADDR_W  SHALL be the read port 1 address.
REQ-007: rr2  input  ADDR_W  SHALL be the read port 2 address.
REQ-008: wr  input  ADDR_W  SHALL be the write address.
REQ-009: wd  input  DATA_W  SHALL be the write data.
REQ-010: regwrite  input  1  SHALL be the write enable.
REQ-011: rsv_en  input  1  SHALL be the scoreboard reserve strobe, marking a register as awaiting a pending write.
REQ-012: rsv_addr  input  ADDR_W  SHALL be the register address to reserve.
REQ-013: rd1  output  DATA_W  SHALL be the read port 1 data.
REQ-014: rd2  output  DATA_W  SHALL be the read port 2 data.
REQ-015: busy1  output  1  SHALL be high when register rr1 holds a pending reservation.
REQ-016: busy2  output  1  SHALL be high when register rr2 holds a pending reservation.

Function
REQ-017: Register 0 SHALL always read as 0, SHALL ignore writes, and SHALL never be busy; reserving it is a no-op.
REQ-018: Registers 1..NREGS-1 SHALL be written with wd at the rising clock edge when regwrite=1 and wr equals the register index.
REQ-019: rd1/rd2 SHALL be combinational reads of the registers at rr1/rr2 with zero-cycle latency; both ports MAY address the same register.
REQ-020: When BYPASS=1, regwrite=1, wr!=0 and wr==rrN, rdN SHALL equal wd in the same cycle and busyN SHALL be 0.
REQ-021: When BYPASS=0, rdN SHALL show the old value until the edge and the new value after it.
REQ-022: The scoreboard SHALL hold one busy bit per register; rsv_en=1 SHALL set bit rsv_addr at the edge.
REQ-023: A write (regwrite=1) SHALL clear the busy bit of wr at the same edge as the data update.
REQ-024: A simultaneous reserve and write to the same address SHALL leave the bit set (reserve wins) and SHALL still store wd.
REQ-025: Reserve and write to different addresses in the same cycle SHALL both take effect.
REQ-026: Reserving an already-busy register SHALL keep it busy; no counting or nesting is provided.
REQ-027: busy1/busy2 SHALL be combinational reads of the busy bits at rr1/rr2, subject to REQ-017 and REQ-020.
REQ-028: With regwrite=0, no register and no busy bit SHALL change except through rsv_en.
REQ-029: Address inputs SHALL be decoded in full; no address value is illegal.

Reset
REQ-030: reset_n=0 SHALL immediately, independent of clock, clear all registers to 0 and all busy bits to 0.
REQ-031: While reset_n=0, writes and reserves SHALL be ignored; rd1, rd2, busy1 and busy2 SHALL be 0 except forwarded wd when BYPASS=1 (REQ-020).
REQ-032: Reset asserted between a reserve and its write SHALL discard the reservation; the later write SHALL store normally.
REQ-033: The first edge after reset_n rises SHALL behave as a normal operating edge.

Verification
REQ-034: Reset, then read all addresses -> rd1=rd2=16'h0000, busy1=busy2=0 for rr=0..3.
REQ-035: Write 16'hA5A5 to reg 1, 16'h1234 to reg 2, 16'hFFFF to reg 3, then rr1=1, rr2=3 -> rd1=16'hA5A5, rd2=16'hFFFF; write 16'hBEEF to reg 0 -> rr1=0 gives 16'h0000.
REQ-036: BYPASS=1: regwrite=1, wr=2, wd=16'h00C3, rr1=2 in the same cycle -> rd1=16'h00C3 before the edge. BYPASS=0: rd1=16'h1234 before the edge and 16'h00C3 after it.
REQ-037: rsv_en with rsv_addr=3 -> busy1=1 at rr1=3 after the edge; next cycle write wr=3, wd=16'h0042 -> busy1=0 and rd1=16'h0042; reserve and write reg 3 in the same cycle -> busy stays 1 and data=16'h0042.
REQ-038: regwrite=0 with wr=1, wd=16'h5555 over 3 edges -> reg 1 unchanged; drop reset_n asynchronously mid-cycle with reg 2 busy -> all data 0 and busy2=0 before the next edge.
